// File: rtl/prog_counter_pkg.sv
// Shared op-code definitions for the program counter and its return stack.
package prog_counter_pkg;

   typedef logic [2:0] op_t;

   localparam op_t OP_HOLD = 3'b000;
   localparam op_t OP_INC  = 3'b001;
   localparam op_t OP_LOAD = 3'b010;
   localparam op_t OP_REL  = 3'b011;
   localparam op_t OP_CALL = 3'b100;
   localparam op_t OP_RET  = 3'b101;

endpackage

// File: rtl/pc_ret_stack.sv
// LIFO of return addresses; entries are not reset, only the count is.
module pc_ret_stack #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RSTB,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] top,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (push && (count == CW'(i))) mem[i] <= data;
      end
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         count <= '0;
      end else if (push) begin
         count <= count + CW'(1);
      end else if (pop) begin
         count <= count - CW'(1);
      end
   end

   // Slots at or above count are stale and must never reach the output.
   always_comb begin
      top = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (count == CW'(i + 1)) top = mem[i];
      end
   end

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/prog_counter_stack.sv
// Program counter with inc/load/relative jumps and call/return through a hardware stack.
module prog_counter_stack
   import prog_counter_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4,
   localparam int SPW  = $clog2(DEPTH + 1)
) (
   input  logic             CLK,
   input  logic             RSTB,
   input  logic             EN,
   input  logic [2:0]       OP,
   input  logic [WIDTH-1:0] IN,
   input  logic             CLR_ERR,
   output logic [WIDTH-1:0] OUT,
   output logic [SPW-1:0]   SP,
   output logic             STK_EMPTY,
   output logic             STK_FULL,
   output logic             ERR
);

   op_t              op;
   logic [WIDTH-1:0] pc_nxt;
   logic [WIDTH-1:0] top;
   logic             push;
   logic             pop;
   logic             err_set;

   assign op = op_t'(OP);

   // Offset is two's complement; wrapping addition makes sign extension implicit.
   function automatic logic [WIDTH-1:0] rel_target(input logic [WIDTH-1:0] pc,
                                                   input logic signed [WIDTH-1:0] off);
      return pc + WIDTH'(1) + unsigned'(off);
   endfunction

   always_comb begin
      pc_nxt  = OUT;
      push    = 1'b0;
      pop     = 1'b0;
      err_set = 1'b0;
      if (EN) begin
         case (op)
            OP_INC:  pc_nxt = OUT + WIDTH'(1);
            OP_LOAD: pc_nxt = IN;
            OP_REL:  pc_nxt = rel_target(OUT, IN);
            OP_CALL: begin
               if (!STK_FULL) begin
                  push   = 1'b1;
                  pc_nxt = IN;
               end else begin
                  err_set = 1'b1;
               end
            end
            OP_RET: begin
               if (!STK_EMPTY) begin
                  pop    = 1'b1;
                  pc_nxt = top;
               end else begin
                  err_set = 1'b1;
               end
            end
            default: pc_nxt = OUT;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         OUT <= '0;
         ERR <= 1'b0;
      end else begin
         OUT <= pc_nxt;
         // A fresh error outranks a simultaneous clear.
         if (err_set)      ERR <= 1'b1;
         else if (CLR_ERR) ERR <= 1'b0;
      end
   end

   pc_ret_stack #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_stack (
      .CLK   (CLK),
      .RSTB  (RSTB),
      .push  (push),
      .pop   (pop),
      .data  (OUT + WIDTH'(1)),
      .top   (top),
      .count (SP),
      .full  (STK_FULL),
      .empty (STK_EMPTY)
   );

endmodule

// File: tb/tb_prog_counter_stack.sv
// Scoreboard bench: stimulus queues expected state, a monitor compares after each edge.
module tb_prog_counter_stack;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int SPW   = $clog2(DEPTH + 1);

   logic             CLK;
   logic             RSTB;
   logic             EN;
   logic [2:0]       OP;
   logic [WIDTH-1:0] IN;
   logic             CLR_ERR;
   logic [WIDTH-1:0] OUT;
   logic [SPW-1:0]   SP;
   logic             STK_EMPTY;
   logic             STK_FULL;
   logic             ERR;

   typedef struct {
      string            name;
      logic [WIDTH-1:0] out;
      logic [SPW-1:0]   sp;
      logic             err;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   prog_counter_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .RSTB      (RSTB),
      .EN        (EN),
      .OP        (OP),
      .IN        (IN),
      .CLR_ERR   (CLR_ERR),
      .OUT       (OUT),
      .SP        (SP),
      .STK_EMPTY (STK_EMPTY),
      .STK_FULL  (STK_FULL),
      .ERR       (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_state(input string name, input logic [WIDTH-1:0] e_out,
                              input logic [SPW-1:0] e_sp, input logic e_err);
      logic e_empty, e_full;
      e_empty = (e_sp == 0);
      e_full  = (e_sp == SPW'(DEPTH));
      n_checks++;
      if (OUT !== e_out) begin
         n_fail++;
         $display("FAIL %s OUT: got %0d expected %0d", name, OUT, e_out);
      end
      n_checks++;
      if (SP !== e_sp) begin
         n_fail++;
         $display("FAIL %s SP: got %0d expected %0d", name, SP, e_sp);
      end
      n_checks++;
      if (ERR !== e_err) begin
         n_fail++;
         $display("FAIL %s ERR: got %b expected %b", name, ERR, e_err);
      end
      n_checks++;
      if (STK_EMPTY !== e_empty || STK_FULL !== e_full) begin
         n_fail++;
         $display("FAIL %s EMPTY/FULL: got %b/%b expected %b/%b",
                  name, STK_EMPTY, STK_FULL, e_empty, e_full);
      end
   endtask

   // Monitor: every edge that has a queued expectation is checked 1 time unit later.
   always @(posedge CLK) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check_state(e.name, e.out, e.sp, e.err);
      end
   end

   task automatic step(input string name, input logic en, input logic [2:0] op,
                       input logic [WIDTH-1:0] in, input logic clr,
                       input logic [WIDTH-1:0] e_out, input logic [SPW-1:0] e_sp,
                       input logic e_err);
      exp_t e;
      @(negedge CLK);
      EN = en; OP = op; IN = in; CLR_ERR = clr;
      e.name = name; e.out = e_out; e.sp = e_sp; e.err = e_err;
      exp_q.push_back(e);
      @(posedge CLK);
   endtask

   initial begin
      RSTB = 1'b0; EN = 1'b0; OP = 3'b000; IN = '0; CLR_ERR = 1'b0;
      #1;
      check_state("reset", 4'd0, 0, 1'b0);
      #13;
      RSTB = 1'b1;

      // 17 increments wrap through zero
      for (int i = 1; i <= 17; i++)
         step($sformatf("inc%0d", i), 1, 3'b001, 4'd0, 0, 4'(i % 16), 0, 0);

      step("load5",    1, 3'b010, 4'd5,  0, 4'd5,  0, 0);
      step("rel_m2",   1, 3'b011, 4'hE,  0, 4'd4,  0, 0);
      step("rel_p7",   1, 3'b011, 4'h7,  0, 4'd12, 0, 0);
      step("op110",    1, 3'b110, 4'd3,  0, 4'd12, 0, 0);
      step("op111",    1, 3'b111, 4'd3,  0, 4'd12, 0, 0);
      step("hold",     1, 3'b000, 4'd3,  0, 4'd12, 0, 0);
      step("load3",    1, 3'b010, 4'd3,  0, 4'd3,  0, 0);
      step("call9",    1, 3'b100, 4'd9,  0, 4'd9,  1, 0);
      step("inc_in_sub", 1, 3'b001, 4'd0, 0, 4'd10, 1, 0);
      step("ret_to4",  1, 3'b101, 4'd0,  0, 4'd4,  0, 0);

      // Nest to full, overflow, unwind, underflow
      step("load0",    1, 3'b010, 4'd0,  0, 4'd0,  0, 0);
      step("call1",    1, 3'b100, 4'd1,  0, 4'd1,  1, 0);
      step("call2",    1, 3'b100, 4'd2,  0, 4'd2,  2, 0);
      step("call3",    1, 3'b100, 4'd3,  0, 4'd3,  3, 0);
      step("call4",    1, 3'b100, 4'd4,  0, 4'd4,  4, 0);
      step("call5_ovf", 1, 3'b100, 4'd5, 0, 4'd4,  4, 1);
      step("ret_a",    1, 3'b101, 4'd0,  0, 4'd4,  3, 1);
      step("ret_b",    1, 3'b101, 4'd0,  0, 4'd3,  2, 1);
      step("ret_c",    1, 3'b101, 4'd0,  0, 4'd2,  1, 1);
      step("ret_d",    1, 3'b101, 4'd0,  0, 4'd1,  0, 1);
      step("ret_unf",  1, 3'b101, 4'd0,  0, 4'd1,  0, 1);

      // Set beats clear on the same edge; clear alone then works
      step("unf_clr",  1, 3'b101, 4'd0,  1, 4'd1,  0, 1);
      step("hold_clr", 1, 3'b000, 4'd0,  1, 4'd1,  0, 0);
      step("en0_inc",  0, 3'b001, 4'd0,  0, 4'd1,  0, 0);
      step("en0_call", 0, 3'b100, 4'd7,  0, 4'd1,  0, 0);

      // Reset mid-sequence drops return addresses
      step("load2",    1, 3'b010, 4'd2,  0, 4'd2,  0, 0);
      step("callA",    1, 3'b100, 4'd6,  0, 4'd6,  1, 0);
      step("callB",    1, 3'b100, 4'd8,  0, 4'd8,  2, 0);
      #2;
      RSTB = 1'b0;
      #1;
      check_state("async_rst", 4'd0, 0, 1'b0);
      RSTB = 1'b1;
      step("ret_after_rst", 1, 3'b101, 4'd0, 0, 4'd0, 0, 1);
      step("en0_clr",  0, 3'b001, 4'd0,  1, 4'd0,  0, 0);
      step("en0_inc2", 0, 3'b001, 4'd0,  0, 4'd0,  0, 0);
      step("inc_last", 1, 3'b001, 4'd0,  0, 4'd1,  0, 0);

      @(negedge CLK);
      EN = 1'b0;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge CLK);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/prog_counter_stack.md
PROG_COUNTER_STACK -- requirements
Module: prog_counter_stack

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, program-counter width in bits (legal 2..16).
REQ-002 The module SHALL have parameter DEPTH, default 4, return-stack entries (legal 1..16).
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset: CLK input 1 is the sole clock, all state rising-edge; RSTB input 1 is the asynchronous active-low reset.
REQ-004 EN  input  1  cycle enable; 0 = all state holds.
REQ-005 OP  input  3  operation code, sampled when EN=1.
REQ-006 IN  input  WIDTH  jump target (LOAD/CALL) or signed two's-complement offset (REL).
REQ-007 CLR_ERR  input  1  clears the sticky error flag.
REQ-008 OUT  output  WIDTH  registered program counter.
REQ-009 SP  output  clog2(DEPTH+1)  registered count of valid stack entries.
REQ-010 STK_EMPTY  output  1  high when SP=0, combinational from SP.
REQ-011 STK_FULL  output  1  high when SP=DEPTH, combinational from SP.
REQ-012 ERR  output  1  registered sticky flag: overflow or underflow has occurred.

Function
REQ-013 OP encoding SHALL be: 000 HOLD, 001 INC, 010 LOAD, 011 REL, 100 CALL, 101 RET; 110/111 SHALL behave as HOLD.
REQ-014 HOLD SHALL leave OUT and the stack unchanged.
REQ-015 INC SHALL set OUT <= OUT+1 modulo 2^WIDTH (all-ones wraps to 0).
REQ-016 LOAD SHALL set OUT <= IN.
REQ-017 REL SHALL set OUT <= OUT+1+IN, IN sign-extended, result modulo 2^WIDTH.
REQ-018 CALL with SP<DEPTH SHALL push (OUT+1) mod 2^WIDTH, increment SP, and set OUT <= IN, all on the same edge.
REQ-019 RET with SP>0 SHALL set OUT <= top entry and decrement SP.
REQ-020 CALL with SP=DEPTH (overflow) SHALL leave OUT, SP and stack contents unchanged and set ERR.
REQ-021 RET with SP=0 (underflow) SHALL leave OUT and SP unchanged and set ERR.
REQ-022 All state changes SHALL take effect at the rising CLK edge where EN=1; latency is one cycle, with no combinational path from inputs to OUT or SP.
REQ-023 With EN=0, OP SHALL be ignored; CLR_ERR SHALL still be honoured.
REQ-024 With CLR_ERR=1 and a new error on the same edge, ERR SHALL end the cycle at 1 (set wins).
REQ-025 The stack SHALL be strictly LIFO; unused entries SHALL never be observable on OUT.

Reset
REQ-026 RSTB=0 SHALL asynchronously force OUT=0, SP=0, ERR=0 regardless of CLK or EN.
REQ-027 Stack entry contents SHALL NOT require reset; SP=0 makes them unreachable.
REQ-028 Reset asserted mid-sequence (e.g. after nested CALLs) SHALL discard all return addresses; a following RET SHALL underflow.
REQ-029 Reset deassertion SHALL need no synchronisation inside the block; the first edge after release SHALL execute OP normally.

Structure
REQ-030 A shared package prog_counter_pkg SHALL hold the OP code constants (OP_HOLD, OP_INC, OP_LOAD, OP_REL, OP_CALL, OP_RET) and the 3-bit op typedef.
REQ-031 The return stack SHALL be a sub-module pc_ret_stack (parameters WIDTH, DEPTH; push/pop/data/top/count/full/empty), with the top module owning OUT, ERR and op decode.

Verification (WIDTH=4, DEPTH=4)
REQ-032 Reset then 17 INC -> OUT steps 1..15, 0, 1; SP stays 0, ERR 0.
REQ-033 OUT=5, REL IN=4'hE (-2) -> OUT=4; then REL IN=4'h7 -> OUT=12.
REQ-034 OUT=3, CALL IN=9 -> OUT=9, SP=1; INC; RET -> OUT=4, SP=0.
REQ-035 Five CALLs IN=1,2,3,4,5 from OUT=0 -> 5th flags ERR=1, OUT=4, SP=4; four RETs -> OUT=4,3,2,1; fifth RET keeps OUT=1, ERR stays 1.
REQ-036 RET at SP=0 with CLR_ERR=1 same edge -> ERR=1; next cycle HOLD with CLR_ERR=1 -> ERR=0.
REQ-037 Two CALLs, then RSTB pulsed low mid-cycle -> OUT=0, SP=0, ERR=0 immediately, before the next edge; EN=0 with OP=INC -> OUT unchanged.
